// File: rtl/vram_pkg.sv
// Shared constants and request type for the VRAM scan-out / CPU arbiter.
// Combinational definitions only: no latency and no backpressure.
package vram_pkg;
  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 8;
  localparam int H_PIXELS     = 300;
  localparam int V_PIXELS     = 150;
  localparam int H_BITS       = 9;
  localparam int V_BITS       = 8;
  localparam int QDEPTH       = 2;
  localparam int FRAME_PIXELS = H_PIXELS * V_PIXELS;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cpu_req_t;

  typedef enum logic {
    TAG_DISP = 1'b0,
    TAG_CPU  = 1'b1
  } rd_tag_e;
endpackage

// File: rtl/vram_scan_arbiter_cpu_req_fifo.sv
// DEPTH-entry request FIFO; the head is visible combinationally, so a push reaches head_o one cycle later.
// Backpressure: full_o from registered occupancy; a push and a pop on the same full cycle are both taken.
module cpu_req_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  cpu_req_t push_dat_i,
  input  logic     pop_i,
  output cpu_req_t head_o,
  output logic     full_o,
  output logic     empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  cpu_req_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/vram_scan_arbiter.sv
// Single-port VRAM slot arbiter: display fetch on active video, queued CPU requests drain in blanking.
// Pixel and CPU read data one cycle after the access; CPU backpressure via cpu_ready_o (queue not full).
module vram_scan_arbiter
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_ena_i,
  input  logic [H_BITS-1:0] col_i,
  input  logic [V_BITS-1:0] row_i,
  input  logic              cpu_valid_i,
  output logic              cpu_ready_o,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              pix_valid_o,
  output logic [DATA_W-1:0] pix_data_o,
  output logic              frame_start_o
);
  cpu_req_t          push_req, head;
  logic              full, empty, push, pop, head_in_range, cpu_rd;
  logic [ADDR_W-1:0] disp_addr;

  logic    pix_valid_q, pix_valid_d;
  logic    frame_start_q, frame_start_d;
  logic    rvalid_q, rvalid_d;
  logic    oor_q, oor_d;
  rd_tag_e rd_tag_q, rd_tag_d;

  assign push_req      = '{we: cpu_we_i, addr: cpu_addr_i, wdata: cpu_wdata_i};
  assign cpu_ready_o   = !full;
  assign push          = cpu_valid_i && !full;
  assign pop           = !rst && !disp_ena_i && !empty;
  assign head_in_range = (head.addr < ADDR_W'(FRAME_PIXELS));
  assign cpu_rd        = pop && !head.we;
  assign disp_addr     = ADDR_W'(row_i) * ADDR_W'(H_PIXELS) + ADDR_W'(col_i);

  cpu_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .push_dat_i(push_req),
    .pop_i     (pop),
    .head_o    (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Out-of-range entries are still popped but never reach the RAM.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!rst && disp_ena_i) begin
      mem_en_o   = 1'b1;
      mem_addr_o = disp_addr;
    end else if (pop && head_in_range) begin
      mem_en_o    = 1'b1;
      mem_we_o    = head.we;
      mem_addr_o  = head.addr;
      mem_wdata_o = head.wdata;
    end
  end

  always_comb begin
    pix_valid_d   = disp_ena_i;
    frame_start_d = disp_ena_i && (row_i == '0) && (col_i == '0);
    rvalid_d      = cpu_rd;
    oor_d         = cpu_rd && !head_in_range;
    rd_tag_d      = cpu_rd ? TAG_CPU : TAG_DISP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      rvalid_q      <= 1'b0;
      oor_q         <= 1'b0;
      rd_tag_q      <= TAG_DISP;
    end else begin
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      rvalid_q      <= rvalid_d;
      oor_q         <= oor_d;
      rd_tag_q      <= rd_tag_d;
    end
  end

  assign pix_valid_o   = pix_valid_q;
  assign pix_data_o    = (pix_valid_q && rd_tag_q == TAG_DISP) ? mem_rdata_i : '0;
  assign cpu_rvalid_o  = rvalid_q;
  assign cpu_rdata_o   = (rvalid_q && rd_tag_q == TAG_CPU && !oor_q) ? mem_rdata_i : '0;
  assign frame_start_o = frame_start_q;
endmodule
